// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one registered-read ROM port among N requesters.
// Read data returns two cycles after ack, tagged with a one-hot rd_valid.
module rom_arbiter #(
  parameter int unsigned N          = 4,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 256,
  parameter bit          HIPRI_EN   = 1'b0,
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N-1:0]            req,
  input  logic [N*ADDR_WIDTH-1:0] req_addr,
  output logic [N-1:0]            ack,
  output logic [N-1:0]            rd_valid,
  output logic [WIDTH-1:0]        rd_data,
  output logic [ADDR_WIDTH-1:0]   rom_addr,
  input  logic [WIDTH-1:0]        rom_data
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic          grant;
  logic [PW-1:0] ptr_nxt;
  logic [PW-1:0] taga;
  logic          va;
  int unsigned   idx;

  // Wrapping search from ptr; requester 0 overrides when high priority is on
  always_comb begin
    grant = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!grant && req[PW'(idx)]) begin
        grant = 1'b1;
        win   = PW'(idx);
      end
    end
    if (HIPRI_EN && req[0]) begin
      grant = 1'b1;
      win   = '0;
    end
  end

  assign ptr_nxt = (win == PW'(N - 1)) ? '0 : win + PW'(1);
  assign ack     = (grant && rstn) ? (N'(1) << win) : '0;
  assign rd_data = rom_data;

  // Stage A: capture winner address and tag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr      <= '0;
      rom_addr <= '0;
      taga     <= '0;
      va       <= 1'b0;
    end else begin
      va <= grant;
      if (grant) begin
        ptr      <= ptr_nxt;
        rom_addr <= req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
        taga     <= win;
      end
    end
  end

  // Stage B: tag travels alongside the ROM's registered read, decoded one-hot
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_valid <= '0;
    end else begin
      rd_valid <= va ? (N'(1) << taga) : '0;
    end
  end

endmodule
